// File: rtl/div32x16_seq_pkg.sv
// Shared encodings and constants for the 32/16 sequential restoring divider.
// Result bundle and helpers are shared by the top and any future wrappers.
package div32x16_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_e;

    localparam int          ITERS = 16;
    localparam logic [15:0] SAT   = 16'hFFFF;

    typedef struct packed {
        logic [15:0] quotient;
        logic [15:0] remainder;
        logic        div_by_zero;
        logic        overflow;
    } res_t;

    // Quotient cannot fit in 16 bits when the high half already reaches the divisor.
    function automatic logic quot_overflows(input logic [15:0] hi, input logic [15:0] dv);
        return (dv != 16'd0) && (hi >= dv);
    endfunction

    function automatic res_t sat_result(input logic dbz, input logic ovf);
        res_t r;
        r.quotient    = SAT;
        r.remainder   = SAT;
        r.div_by_zero = dbz;
        r.overflow    = ovf;
        return r;
    endfunction

endpackage

// File: rtl/cla_nbit.sv
// Parameterised parallel-prefix (Kogge-Stone) carry-lookahead adder: sum = a + b + cin.
// Only the carries into bits 1..N-1 are built; the carry out of the top bit is not produced.
module cla_nbit #(
    parameter int N = 17
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum
);
    localparam int M = N - 1;
    localparam int L = (M > 1) ? $clog2(M) : 1;

    logic [N-1:0]        p;
    logic [N-1:0]        c;
    logic [L:0][M-1:0]   gg;
    logic [L:0][M-1:0]   pg;

    assign p = a ^ b;

    always_comb begin
        gg    = '0;
        pg    = '0;
        gg[0] = a[M-1:0] & b[M-1:0];
        pg[0] = p[M-1:0];
        for (int l = 0; l < L; l++) begin
            for (int i = 0; i < M; i++) begin
                int d;
                int j;
                d = 1 << l;
                j = (i >= d) ? i - d : i;
                if (i >= d) begin
                    gg[l+1][i] = gg[l][i] | (pg[l][i] & gg[l][j]);
                    pg[l+1][i] = pg[l][i] & pg[l][j];
                end else begin
                    gg[l+1][i] = gg[l][i];
                    pg[l+1][i] = pg[l][i];
                end
            end
        end
        c[0] = cin;
        for (int i = 1; i < N; i++) begin
            c[i] = gg[L][i-1] | (pg[L][i-1] & cin);
        end
    end

    assign sum = p ^ c;

endmodule

// File: rtl/div32x16_seq.sv
// Sequential 32/16 unsigned restoring divider: one quotient bit per cycle, 16 CALC cycles.
// Divide-by-zero and quotient overflow short-circuit straight to DONE with saturated results.
module div32x16_seq
    import div32x16_seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] dividend,
    input  logic [15:0] divisor,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] quotient,
    output logic [15:0] remainder,
    output logic        div_by_zero,
    output logic        overflow
);
    state_e      state, state_nxt;
    logic [4:0]  cnt;
    logic [16:0] r;
    logic [15:0] q;
    logic [15:0] dvsr;
    res_t        res;

    logic        accept;
    logic        op_zero;
    logic        op_ovf;
    logic [16:0] shifted;
    logic [16:0] trial;
    logic [16:0] r_step;
    logic [15:0] q_step;
    logic        borrow;
    logic        last_step;

    assign accept  = in_valid && (state == IDLE);
    assign op_zero = (divisor == 16'd0);
    assign op_ovf  = quot_overflows(dividend[31:16], divisor);

    // r < divisor holds throughout CALC, so r[16] is always 0 and drops out of the shift.
    assign shifted = 17'({r, q[15]});

    cla_nbit #(.N(17)) u_trial (
        .a   (shifted),
        .b   (~{1'b0, dvsr}),
        .cin (1'b1),
        .sum (trial)
    );

    assign borrow    = trial[16];
    assign r_step    = borrow ? shifted : trial;
    assign q_step    = {q[14:0], ~borrow};
    assign last_step = (cnt == 5'(ITERS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = (op_zero || op_ovf) ? DONE : CALC;
            CALC: if (last_step) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            r    <= '0;
            q    <= '0;
            dvsr <= '0;
            res  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        dvsr <= divisor;
                        r    <= {1'b0, dividend[31:16]};
                        q    <= dividend[15:0];
                        cnt  <= '0;
                        if (op_zero)     res <= sat_result(1'b1, 1'b0);
                        else if (op_ovf) res <= sat_result(1'b0, 1'b1);
                    end
                end
                CALC: begin
                    r   <= r_step;
                    q   <= q_step;
                    cnt <= cnt + 5'd1;
                    if (last_step) begin
                        res.quotient    <= q_step;
                        res.remainder   <= r_step[15:0];
                        res.div_by_zero <= 1'b0;
                        res.overflow    <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready    = (state == IDLE);
    assign out_valid   = (state == DONE);
    assign quotient    = res.quotient;
    assign remainder   = res.remainder;
    assign div_by_zero = res.div_by_zero;
    assign overflow    = res.overflow;

endmodule

// File: tb/tb_div32x16_seq.sv
// Directed bench for div32x16_seq: reset, latency, saturation paths, backpressure,
// mid-CALC reset and a short random sweep checked against the simulator's own / and %.
module tb_div32x16_seq;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        div_by_zero;
    logic        overflow;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    div32x16_seq dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .dividend    (dividend),
        .divisor     (divisor),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero),
        .overflow    (overflow)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Drive one operation; operands are scrambled and in_valid held high after accept
    // so that anything sampled outside the accept edge would corrupt the result.
    task automatic run_op(input logic [31:0] dd, input logic [15:0] dv, output int lat);
        int guard;
        @(negedge clk);
        dividend = dd;
        divisor  = dv;
        in_valid = 1'b1;
        guard    = 0;
        while (!in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        if (!in_ready) chk("accept_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        dividend = $urandom;
        divisor  = 16'($urandom);
        lat      = 0;
        while (lat < 40) begin
            @(negedge clk);
            lat++;
            if (out_valid) break;
        end
        in_valid = 1'b0;
        if (!out_valid) chk("result_timeout", 32'(out_valid), 32'd1);
    endtask

    task automatic finish_op();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("post_hs_in_ready", 32'(in_ready), 32'd1);
        chk("post_hs_out_valid", 32'(out_valid), 32'd0);
    endtask

    task automatic check_res(input string tag, input logic [15:0] eq, input logic [15:0] er,
                             input logic edz, input logic eov);
        chk({tag, "_q"},   32'(quotient),    32'(eq));
        chk({tag, "_r"},   32'(remainder),   32'(er));
        chk({tag, "_dbz"}, 32'(div_by_zero), 32'(edz));
        chk({tag, "_ovf"}, 32'(overflow),    32'(eov));
    endtask

    initial begin
        int          lat;
        logic [31:0] dd;
        logic [15:0] dv;

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        dividend  = '0;
        divisor   = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        check_res("rst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        rst_n = 1'b1;

        // 100 / 7 = 14 r 2, 17-cycle latency
        run_op(32'h0000_0064, 16'h0007, lat);
        chk("lat_normal", 32'(lat), 32'd17);
        check_res("d100_7", 16'h000E, 16'h0002, 1'b0, 1'b0);
        finish_op();
        chk("hold_after_done_q", 32'(quotient), 32'h000E);

        // Inverse of FFFF*FFFF
        run_op(32'hFFFE_0001, 16'hFFFF, lat);
        check_res("max_prod", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        finish_op();

        // Divide by zero, 1-cycle latency
        run_op(32'h1234_5678, 16'h0000, lat);
        chk("lat_zero", 32'(lat), 32'd1);
        check_res("dbz", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        finish_op();

        // Overflow, high half equal to divisor
        run_op(32'h0001_0000, 16'h0001, lat);
        chk("lat_ovf", 32'(lat), 32'd1);
        check_res("ovf1", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        finish_op();
        run_op(32'h0007_0000, 16'h0007, lat);
        check_res("ovf7", 16'hFFFF, 16'hFFFF, 1'b0, 1'b1);
        finish_op();

        // Largest non-overflow quotients and other edges
        run_op(32'h0000_FFFF, 16'h0001, lat);
        check_res("ffff_1", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        finish_op();
        run_op(32'h0001_FFFF, 16'h0002, lat);
        check_res("1ffff_2", 16'hFFFF, 16'h0001, 1'b0, 1'b0);
        finish_op();
        run_op(32'h00FF_FFFF, 16'h0100, lat);
        check_res("ffffff_100", 16'hFFFF, 16'h00FF, 1'b0, 1'b0);
        finish_op();
        run_op(32'h0006_0000, 16'h0007, lat);
        check_res("60000_7", 16'hDB6D, 16'h0005, 1'b0, 1'b0);
        finish_op();
        run_op(32'h0000_0000, 16'h0005, lat);
        check_res("zero_5", 16'h0000, 16'h0000, 1'b0, 1'b0);
        finish_op();

        // Backpressure in DONE with inputs churning
        run_op(32'h0000_0064, 16'h0007, lat);
        for (int i = 0; i < 5; i++) begin
            in_valid  = i[0];
            dividend  = $urandom;
            divisor   = 16'($urandom);
            out_ready = 1'b0;
            @(negedge clk);
            chk("bp_out_valid", 32'(out_valid), 32'd1);
            chk("bp_in_ready", 32'(in_ready), 32'd0);
            check_res("bp", 16'h000E, 16'h0002, 1'b0, 1'b0);
        end
        in_valid = 1'b0;
        finish_op();

        // Reset pulse after 8 CALC iterations
        @(negedge clk);
        dividend = 32'hFFFE_0001;
        divisor  = 16'hFFFF;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("midrst_in_ready", 32'(in_ready), 32'd1);
        chk("midrst_out_valid", 32'(out_valid), 32'd0);
        check_res("midrst", 16'h0000, 16'h0000, 1'b0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        run_op(32'h0000_0064, 16'h0007, lat);
        chk("after_rst_lat", 32'(lat), 32'd17);
        check_res("after_rst", 16'h000E, 16'h0002, 1'b0, 1'b0);
        finish_op();

        // Random non-overflow, non-zero pairs
        for (int n = 0; n < 300; n++) begin
            dv = 16'($urandom_range(65535, 1));
            dd = {16'($urandom % 32'(dv)), 16'($urandom)};
            run_op(dd, dv, lat);
            chk("rnd_q", 32'(quotient), dd / 32'(dv));
            chk("rnd_r", 32'(remainder), dd % 32'(dv));
            finish_op();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
